// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store unit. Converts the registered EX/MEM address, store
// data and control into a single req/ack transaction on the data-memory bus,
// stalls the pipeline until that transaction completes, and returns aligned,
// extended load data. Flags misaligned/illegal accesses and bus timeouts.
//
// Ports:
//   clk                clock, all state changes on the rising edge
//   rst                synchronous active-low reset
//   i_alu_result       byte address
//   i_write_data       store data
//   i_ctrl_mem_write   store request (wins if both requests are high)
//   i_ctrl_mem2reg     load request
//   i_ctrl_word_size   funct3 size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_stall            combinational pipeline freeze
//   o_dmem_req         bus request (registered)
//   o_dmem_we          bus write enable
//   o_dmem_addr        word-aligned bus address
//   o_dmem_wdata       lane-replicated store data
//   o_dmem_be          byte enables
//   i_dmem_ack         one-cycle completion strobe
//   i_dmem_rdata       read word, valid with i_dmem_ack
//   o_mem_data         extended load result (registered)
//   o_misaligned       one-cycle pulse for a misaligned or illegal access
//   o_bus_error        one-cycle pulse when a transaction times out
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned OPERAND_WIDTH  = 32,  // only 32 is supported
  parameter int unsigned TIMEOUT_CYCLES = 16   // 1..255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPERAND_WIDTH-1:0] i_alu_result,
  input  logic [OPERAND_WIDTH-1:0] i_write_data,
  input  logic                     i_ctrl_mem_write,
  input  logic                     i_ctrl_mem2reg,
  input  logic [2:0]               i_ctrl_word_size,
  output logic                     o_stall,
  output logic                     o_dmem_req,
  output logic                     o_dmem_we,
  output logic [OPERAND_WIDTH-1:0] o_dmem_addr,
  output logic [OPERAND_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]               o_dmem_be,
  input  logic                     i_dmem_ack,
  input  logic [OPERAND_WIDTH-1:0] i_dmem_rdata,
  output logic [OPERAND_WIDTH-1:0] o_mem_data,
  output logic                     o_misaligned,
  output logic                     o_bus_error
);

  // Reset level shared with the rest of the core (active low).
  localparam logic RESET = 1'b0;

  // Last BUSY count value before the transaction is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e                     r_state;
  logic [7:0]                 r_cnt;
  logic                       r_req;
  logic                       r_we;
  logic [OPERAND_WIDTH-1:0]   r_addr;
  logic [OPERAND_WIDTH-1:0]   r_wdata;
  logic [3:0]                 r_be;
  logic                       r_is_load;
  logic [2:0]                 r_size;
  logic [1:0]                 r_lo;
  logic [OPERAND_WIDTH-1:0]   r_mem_data;
  logic                       r_misaligned;
  logic                       r_bus_error;

  logic                       w_access;
  logic                       w_is_store;
  logic [1:0]                 w_lo;
  logic                       w_bad;
  logic [3:0]                 w_be;
  logic [OPERAND_WIDTH-1:0]   w_wdata;
  logic [7:0]                 w_byte;
  logic [15:0]                w_half;
  logic [OPERAND_WIDTH-1:0]   w_load_data;

  assign w_access   = i_ctrl_mem_write | i_ctrl_mem2reg;
  assign w_is_store = i_ctrl_mem_write;
  assign w_lo       = i_alu_result[1:0];

  // Illegal size codes, misaligned halves/words, and stores of unsigned sizes.
  always_comb begin
    w_bad = 1'b0;
    case (i_ctrl_word_size)
      3'b000:  w_bad = 1'b0;
      3'b001:  w_bad = w_lo[0];
      3'b010:  w_bad = |w_lo;
      3'b100:  w_bad = w_is_store;
      3'b101:  w_bad = w_lo[0] | w_is_store;
      default: w_bad = 1'b1;
    endcase
  end

  // Byte enables and lane replication; size[1:0] covers both signed and
  // unsigned variants since illegal combinations never reach the bus.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_write_data;
    case (i_ctrl_word_size[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_write_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_write_data;
      end
    endcase
  end

  // Lane extraction uses the registered offset/size so the bus phase does not
  // depend on the upstream inputs.
  always_comb begin
    w_byte = i_dmem_rdata[7:0];
    case (r_lo)
      2'd0:    w_byte = i_dmem_rdata[7:0];
      2'd1:    w_byte = i_dmem_rdata[15:8];
      2'd2:    w_byte = i_dmem_rdata[23:16];
      default: w_byte = i_dmem_rdata[31:24];
    endcase
    w_half = r_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

    w_load_data = '0;
    case (r_size)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = i_dmem_rdata;
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_is_load    <= 1'b0;
      r_size       <= '0;
      r_lo         <= '0;
      r_mem_data   <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_access) begin
            if (w_bad) begin
              r_misaligned <= 1'b1;
              if (!w_is_store) begin
                r_mem_data <= '0;
              end
            end else begin
              r_we      <= w_is_store;
              r_addr    <= {i_alu_result[31:2], 2'b00};
              r_wdata   <= w_wdata;
              r_be      <= w_be;
              r_is_load <= ~w_is_store;
              r_size    <= i_ctrl_word_size;
              r_lo      <= w_lo;
              r_req     <= 1'b1;
              r_cnt     <= '0;
              r_state   <= StBusy;
            end
          end
        end
        StBusy: begin
          // Ack takes priority over a simultaneous timeout.
          if (i_dmem_ack) begin
            if (r_is_load) begin
              r_mem_data <= w_load_data;
            end
            r_req   <= 1'b0;
            r_state <= StDone;
          end else if (r_cnt == TO_LAST) begin
            if (r_is_load) begin
              r_mem_data <= '0;
            end
            r_bus_error <= 1'b1;
            r_req       <= 1'b0;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          // The held instruction leaves this cycle; never re-issue it.
          r_cnt   <= '0;
          r_state <= StIdle;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_stall      = ((r_state == StIdle) & w_access & ~w_bad) | (r_state == StBusy);
  assign o_dmem_req   = r_req;
  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_wdata = r_wdata;
  assign o_dmem_be    = r_be;
  assign o_mem_data   = r_mem_data;
  assign o_misaligned = r_misaligned;
  assign o_bus_error  = r_bus_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; load results go through a scoreboard queue.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] i_alu_result;
  logic [31:0] i_write_data;
  logic        i_ctrl_mem_write;
  logic        i_ctrl_mem2reg;
  logic [2:0]  i_ctrl_word_size;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_mem_data;
  logic        o_misaligned;
  logic        o_bus_error;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_mem = 32'h0;

  load_store_unit #(
    .OPERAND_WIDTH (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_alu_result    (i_alu_result),
    .i_write_data    (i_write_data),
    .i_ctrl_mem_write(i_ctrl_mem_write),
    .i_ctrl_mem2reg  (i_ctrl_mem2reg),
    .i_ctrl_word_size(i_ctrl_word_size),
    .o_stall         (o_stall),
    .o_dmem_req      (o_dmem_req),
    .o_dmem_we       (o_dmem_we),
    .o_dmem_addr     (o_dmem_addr),
    .o_dmem_wdata    (o_dmem_wdata),
    .o_dmem_be       (o_dmem_be),
    .i_dmem_ack      (i_dmem_ack),
    .i_dmem_rdata    (i_dmem_rdata),
    .o_mem_data      (o_mem_data),
    .o_misaligned    (o_misaligned),
    .o_bus_error     (o_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'h0, obs}, {31'h0, exp});
  endtask

  // Pop the oldest expected load result and compare it with o_mem_data.
  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty scoreboard, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/mem_data"}, o_mem_data, e);
      cur_mem = e;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    i_ctrl_mem_write = 1'b0;
    i_ctrl_mem2reg   = 1'b0;
    i_ctrl_word_size = 3'b000;
    i_alu_result     = 32'h0;
    i_write_data     = 32'h0;
  endtask

  // One legal access. waits = BUSY cycles before ack (-1: never ack).
  task automatic xact(input string tag, input logic st, input logic ld, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                      input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wd, input logic [31:0] e_data);
    int   stalls;
    logic acked;
    logic is_load;
    is_load          = ld & ~st;
    i_ctrl_mem_write = st;
    i_ctrl_mem2reg   = ld;
    i_ctrl_word_size = sz;
    i_alu_result     = a;
    i_write_data     = d;
    if (is_load) exp_q.push_back(e_data);
    stalls = 0;
    acked  = 1'b0;
    @(negedge clk);
    if (o_stall) stalls++;
    chk1({tag, "/idle_stall"}, o_stall, 1'b1);
    chk1({tag, "/idle_req"}, o_dmem_req, 1'b0);
    step();
    for (int k = 0; k < int'(TO); k++) begin
      i_dmem_ack   = (k == waits);
      i_dmem_rdata = (k == waits) ? rd : 32'h5A5A_A5A5;
      @(negedge clk);
      if (o_stall) stalls++;
      chk1({tag, "/busy_req"}, o_dmem_req, 1'b1);
      if (k == 0 || k == waits) begin
        chk({tag, "/addr"}, o_dmem_addr, e_addr);
        chk({tag, "/be"}, {28'h0, o_dmem_be}, {28'h0, e_be});
        chk1({tag, "/we"}, o_dmem_we, st);
        if (st) chk({tag, "/wdata"}, o_dmem_wdata, e_wd);
        chk({tag, "/hold_mem"}, o_mem_data, cur_mem);
      end
      step();
      i_dmem_ack = 1'b0;
      if (k == waits) begin
        acked = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (o_stall) stalls++;
    chk1({tag, "/done_stall"}, o_stall, 1'b0);
    chk1({tag, "/done_req"}, o_dmem_req, 1'b0);
    chk1({tag, "/bus_error"}, o_bus_error, ~acked);
    if (is_load) pop_chk(tag);
    else chk({tag, "/store_keeps_mem"}, o_mem_data, cur_mem);
    chk({tag, "/stall_cycles"}, stalls, acked ? waits + 2 : int'(TO) + 1);
    step();
    nop();
    @(negedge clk);
    chk1({tag, "/after_err"}, o_bus_error, 1'b0);
    chk1({tag, "/after_stall"}, o_stall, 1'b0);
    step();
  endtask

  // Misaligned or illegal access: pulse only, no bus cycle, no stall.
  task automatic bad_access(input string tag, input logic st, input logic ld,
                            input logic [2:0] sz, input logic [31:0] a);
    i_ctrl_mem_write = st;
    i_ctrl_mem2reg   = ld;
    i_ctrl_word_size = sz;
    i_alu_result     = a;
    i_write_data     = 32'hFFFF_FFFF;
    if (ld & ~st) exp_q.push_back(32'h0);
    @(negedge clk);
    chk1({tag, "/stall"}, o_stall, 1'b0);
    chk1({tag, "/pre_pulse"}, o_misaligned, 1'b0);
    step();
    nop();
    @(negedge clk);
    chk1({tag, "/pulse"}, o_misaligned, 1'b1);
    chk1({tag, "/req"}, o_dmem_req, 1'b0);
    if (ld & ~st) pop_chk(tag);
    else chk({tag, "/store_keeps_mem"}, o_mem_data, cur_mem);
    step();
    @(negedge clk);
    chk1({tag, "/pulse_end"}, o_misaligned, 1'b0);
    step();
  endtask

  initial begin
    rst          = 1'b0;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'h0;
    nop();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("reset/req", o_dmem_req, 1'b0);
    chk1("reset/stall", o_stall, 1'b0);
    chk("reset/mem_data", o_mem_data, 32'h0);
    chk("reset/addr", o_dmem_addr, 32'h0);
    chk1("reset/misaligned", o_misaligned, 1'b0);
    chk1("reset/bus_error", o_bus_error, 1'b0);
    step();
    rst = 1'b1;
    step();

    // Non-memory instruction: no stall, no bus activity.
    @(negedge clk);
    chk1("nop/stall", o_stall, 1'b0);
    chk1("nop/req", o_dmem_req, 1'b0);
    step();

    xact("lb", 1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
         32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80);
    xact("sh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3,
         32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0);
    xact("lbu", 1'b0, 1'b1, 3'b100, 32'h101, 32'h0, 32'h0000_9A00, 1,
         32'h100, 4'b0010, 32'h0, 32'h0000_009A);
    xact("lh", 1'b0, 1'b1, 3'b001, 32'h002, 32'h0, 32'h8001_7FFF, 0,
         32'h0, 4'b1100, 32'h0, 32'hFFFF_8001);
    xact("sb", 1'b1, 1'b0, 3'b000, 32'h301, 32'h0000_00A5, 32'h0, 0,
         32'h300, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    // Both request lines high is a store.
    xact("sw_both", 1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 1,
         32'h400, 4'b1111, 32'hCAFE_F00D, 32'h0);

    bad_access("lw_misal", 1'b0, 1'b1, 3'b010, 32'h001);
    xact("lh_lo", 1'b0, 1'b1, 3'b001, 32'h010, 32'h0, 32'hFFFF_1234, 0,
         32'h010, 4'b0011, 32'h0, 32'h0000_1234);
    bad_access("sbu_illegal", 1'b1, 1'b0, 3'b100, 32'h000);
    bad_access("lh_odd", 1'b0, 1'b1, 3'b001, 32'h003);
    bad_access("size011", 1'b0, 1'b1, 3'b011, 32'h000);

    xact("lhu_timeout", 1'b0, 1'b1, 3'b101, 32'h006, 32'h0, 32'h0, -1,
         32'h004, 4'b1100, 32'h0, 32'h0);
    xact("lw_collide", 1'b0, 1'b1, 3'b010, 32'h020, 32'h0, 32'h0BAD_F00D, int'(TO) - 1,
         32'h020, 4'b1111, 32'h0, 32'h0BAD_F00D);

    // Spurious ack in IDLE is ignored.
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk1("spurious/req", o_dmem_req, 1'b0);
    step();
    i_dmem_ack = 1'b0;
    @(negedge clk);
    chk("spurious/mem_data", o_mem_data, cur_mem);
    chk1("spurious/bus_error", o_bus_error, 1'b0);
    step();

    // Reset while BUSY abandons the transaction.
    i_ctrl_mem2reg   = 1'b1;
    i_ctrl_word_size = 3'b010;
    i_alu_result     = 32'h40;
    i_write_data     = 32'h1111_1111;
    step();
    @(negedge clk);
    chk1("rst_busy/req_before", o_dmem_req, 1'b1);
    rst = 1'b0;
    nop();
    step();
    @(negedge clk);
    chk1("rst_busy/req", o_dmem_req, 1'b0);
    chk1("rst_busy/we", o_dmem_we, 1'b0);
    chk("rst_busy/addr", o_dmem_addr, 32'h0);
    chk("rst_busy/wdata", o_dmem_wdata, 32'h0);
    chk("rst_busy/be", {28'h0, o_dmem_be}, 32'h0);
    chk("rst_busy/mem_data", o_mem_data, 32'h0);
    chk1("rst_busy/stall", o_stall, 1'b0);
    chk1("rst_busy/bus_error", o_bus_error, 1'b0);
    chk1("rst_busy/misaligned", o_misaligned, 1'b0);
    cur_mem = 32'h0;
    rst = 1'b1;
    step();
    xact("lw_after_rst", 1'b0, 1'b1, 3'b010, 32'h010, 32'h0, 32'hDEAD_BEEF, 0,
         32'h010, 4'b1111, 32'h0, 32'hDEAD_BEEF);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: observed %0d entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting between the `ex_mem` and `mem_wb` stage registers. It turns the registered EX/MEM address, store data, and control into a request/acknowledge transaction on the data-memory bus. It stalls the pipeline until that transaction completes and returns aligned, sign- or zero-extended load data to `mem_wb.i_mem_data`. It also flags misaligned or illegal accesses and bus timeouts.

## Interface
Parameters:
- `OPERAND_WIDTH`, 32, data width; only 32 is supported.
- `TIMEOUT_CYCLES`, 16, maximum BUSY cycles without ack before a bus error; range 1..255.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-low, compared against `RESET` from `common`.
- `i_alu_result`  in  32  byte address, from `ex_mem.o_alu_result`.
- `i_write_data`  in  32  store data.
- `i_ctrl_mem_write`  in  1  store request.
- `i_ctrl_mem2reg`  in  1  load request.
- `i_ctrl_word_size`  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `o_stall`  out  1  combinational; freezes PC, `if_id`, `id_ex` and `ex_mem`.
- `o_dmem_req`  out  1  bus request (registered).
- `o_dmem_we`  out  1  1 = write.
- `o_dmem_addr`  out  32  word address, `{i_alu_result[31:2], 2'b00}`.
- `o_dmem_wdata`  out  32  lane-replicated store data.
- `o_dmem_be`  out  4  byte enables.
- `i_dmem_ack`  in  1  one-cycle completion strobe.
- `i_dmem_rdata`  in  32  read word; valid when `i_dmem_ack` is high.
- `o_mem_data`  out  32  extended load result (registered).
- `o_misaligned`  out  1  one-cycle pulse for a misaligned or illegal access.
- `o_bus_error`  out  1  one-cycle pulse when a transaction times out.

## Operation
- **Access detection.** `access = i_ctrl_mem_write | i_ctrl_mem2reg`. If both are high, the access is a store.
- **Illegal or misaligned access** (`bad`):
  - H/HU with `addr[0]` set.
  - W with `addr[1:0]` non-zero.
  - Size codes 011, 110 or 111.
  - Stores with BU or HU.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE**
  - `access & bad`: pulse `o_misaligned`; load sets `o_mem_data` = 0; no bus cycle, no stall; stay in IDLE.
  - `access & ~bad`: register `we`, `addr`, `wdata` and `be`; set `o_dmem_req` = 1; go to BUSY.
- **BUSY**
  - `o_dmem_req` is held at 1 and all bus outputs are stable.
  - The timeout counter increments each cycle.
  - `i_dmem_ack`: on a load, capture the extended data into `o_mem_data`; drop req; go to DONE.
  - Counter reaches `TIMEOUT_CYCLES - 1` with no ack: drop req; pulse `o_bus_error` in DONE; a load sets `o_mem_data` = 0; go to DONE.
  - Ack in the same cycle as the timeout: ack wins, no error.
- **DONE**
  - Lasts one cycle. `o_stall` is 0, so the pipeline advances at the end of this cycle.
  - Always returns to IDLE. The held instruction is never re-issued.
- **Stall.** `o_stall = (IDLE & access & ~bad) | BUSY`.
- **Byte enables and store data:**
  - B: `be = 1 << addr[1:0]`, wdata = byte replicated ×4.
  - H: `be = addr[1] ? 1100 : 0011`, wdata = half replicated ×2.
  - W: `be = 1111`, wdata = data.
- **Load extraction.** Select the byte or half by `addr[1:0]` from `i_dmem_rdata`. B/H sign-extend; BU/HU zero-extend; W passes through.
- **Hold behaviour.** `o_mem_data` holds its value except on load completion or a load error.
- **Spurious ack.** `i_dmem_ack` outside BUSY is ignored.

## Timing
- **Reset values.** All outputs are 0, state is IDLE, the counter is 0.
- **Reset mid-BUSY.** `o_dmem_req` is 0 from the next cycle. No error is reported and the transaction is abandoned.
- **Load latency.** With ack in the first BUSY cycle:
  - Cycle 0: IDLE, `o_stall` = 1.
  - Cycle 1: BUSY, req and ack.
  - Cycle 2: DONE, `o_mem_data` valid, `o_stall` = 0.
  - Total: 2 stall cycles. Each extra wait cycle adds one stall cycle.
- **Input stability.** Inputs must be stable while `o_stall` = 1; upstream registers guarantee this.
- **Non-memory instructions.** `o_stall` = 0 and there is no bus activity.
- **Back-to-back accesses.** The next access is seen in IDLE on the cycle after DONE.
- **Pulse timing.** `o_misaligned` is asserted in the cycle after the offending IDLE cycle. `o_bus_error` is asserted in the DONE cycle.

## Test plan
- **LB with sign extension.** LB at addr 0x103, rdata 0x80FF_0000, ack on first BUSY cycle → be 1000, `o_mem_data` 0xFFFF_FF80 in cycle 2, stall high for cycles 0–1.
- **SH with wait states.** SH addr 0x202, data 0x1234_ABCD, ack after 3 wait cycles → addr 0x200, be 1100, wdata 0xABCD_ABCD, we 1; stall for 5 cycles.
- **Misaligned word.** LW addr 0x001 → `o_misaligned` 1 for one cycle, `o_mem_data` 0, req never asserted, stall never asserted.
- **Timeout.** LHU with no ack and `TIMEOUT_CYCLES` = 4 → req high for 4 cycles, then `o_bus_error` pulse, `o_mem_data` 0, return to IDLE.
- **Reset mid-BUSY.** `rst` low during BUSY → req 0 and all outputs 0 next cycle. A subsequent LW at 0x10 with rdata 0xDEAD_BEEF → `o_mem_data` 0xDEAD_BEEF.
- **Ack/timeout collision.** Ack on the timeout cycle → data captured, `o_bus_error` stays 0.
